pipeline_regs: RTL and testbench

//  Consumer of the pipeline-control outputs: holds the F, D, E, M and W pipeline registers and the condition-code register.

---
 rtl/pipeline_regs.sv | 120 ++++++++++++
 tb/tb_pipeline_regs.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_regs.sv
// F/D/E/M/W pipeline registers and condition codes with per-stage load/stall/bubble control,
// a sticky stall-vs-bubble conflict flag and saturating stall/bubble counters.
module pipeline_regs #(
    parameter int              DW       = 64,
    parameter logic [DW-1:0]   RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                F_stall,
    input  logic                D_stall,
    input  logic                D_bubble,
    input  logic                E_bubble,
    input  logic                M_bubble,
    input  logic                W_stall,
    input  logic                set_cc,
    input  logic [DW-1:0]       f_predPC,
    input  logic [18+2*DW-1:0]  d_in,
    input  logic [26+3*DW-1:0]  e_in,
    input  logic [15+2*DW-1:0]  m_in,
    input  logic [14+2*DW-1:0]  w_in,
    input  logic [2:0]          e_cc,
    output logic [DW-1:0]       F_predPC,
    output logic [18+2*DW-1:0]  D_out,
    output logic [26+3*DW-1:0]  E_out,
    output logic [15+2*DW-1:0]  M_out,
    output logic [14+2*DW-1:0]  W_out,
    output logic [2:0]          cc,
    output logic                ctrl_err,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);

    localparam int D_W = 18 + 2*DW;
    localparam int E_W = 26 + 3*DW;
    localparam int M_W = 15 + 2*DW;
    localparam int W_W = 14 + 2*DW;

    localparam logic [1:0]       STAT_AOK  = 2'b00;
    localparam logic [3:0]       ICODE_NOP = 4'h1;
    localparam logic [3:0]       REG_NONE  = 4'hF;
    localparam logic [2:0]       CC_RESET  = 3'b100;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    // Bubble values: a nop with no destination registers, so nothing downstream forwards from it.
    localparam logic [D_W-1:0] D_NOP = {STAT_AOK, ICODE_NOP, 4'h0, REG_NONE, REG_NONE,
                                        {(2*DW){1'b0}}};
    localparam logic [E_W-1:0] E_NOP = {STAT_AOK, ICODE_NOP, 4'h0, {(3*DW){1'b0}},
                                        REG_NONE, REG_NONE, REG_NONE, REG_NONE};
    localparam logic [M_W-1:0] M_NOP = {STAT_AOK, ICODE_NOP, 1'b0, {(2*DW){1'b0}},
                                        REG_NONE, REG_NONE};
    localparam logic [W_W-1:0] W_NOP = {STAT_AOK, ICODE_NOP, {(2*DW){1'b0}},
                                        REG_NONE, REG_NONE};

    logic [DW-1:0]    f_next;
    logic [D_W-1:0]   d_next;
    logic [E_W-1:0]   e_next;
    logic [M_W-1:0]   m_next;
    logic [W_W-1:0]   w_next;
    logic [2:0]       cc_next;
    logic             conflict;
    logic             any_bubble;
    logic [CNT_W-1:0] stall_cnt_next;
    logic [CNT_W-1:0] bubble_cnt_next;

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        f_next          = f_predPC;
        d_next          = d_in;
        e_next          = e_in;
        m_next          = m_in;
        w_next          = w_in;
        cc_next         = cc;
        stall_cnt_next  = stall_cnt;
        bubble_cnt_next = bubble_cnt;

        conflict   = D_stall && D_bubble;
        any_bubble = D_bubble || E_bubble || M_bubble;

        if (F_stall) f_next = F_predPC;

        // A stall beats a bubble on D; the conflict itself is recorded in ctrl_err.
        if (D_stall)       d_next = D_out;
        else if (D_bubble) d_next = D_NOP;

        if (E_bubble) e_next = E_NOP;
        if (M_bubble) m_next = M_NOP;
        if (W_stall)  w_next = W_out;
        if (set_cc)   cc_next = e_cc;

        if (F_stall && (stall_cnt != CNT_MAX))     stall_cnt_next  = stall_cnt + 1'b1;
        if (any_bubble && (bubble_cnt != CNT_MAX)) bubble_cnt_next = bubble_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            F_predPC   <= RESET_PC;
            D_out      <= D_NOP;
            E_out      <= E_NOP;
            M_out      <= M_NOP;
            W_out      <= W_NOP;
            cc         <= CC_RESET;
            ctrl_err   <= 1'b0;
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            F_predPC   <= f_next;
            D_out      <= d_next;
            E_out      <= e_next;
            M_out      <= m_next;
            W_out      <= w_next;
            cc         <= cc_next;
            ctrl_err   <= ctrl_err || conflict;
            stall_cnt  <= stall_cnt_next;
            bubble_cnt <= bubble_cnt_next;
        end
    end

endmodule

// File: tb/tb_pipeline_regs.sv
// Directed, table-driven bench for pipeline_regs: reset, load-use, mispredict, halt,
// stall/bubble conflict and counter saturation with a narrow counter.
module tb_pipeline_regs;

    localparam int            DW       = 64;
    localparam int            CNT_W    = 4;
    localparam logic [DW-1:0] RESET_PC = 64'h0000_0000_0000_1000;
    localparam int            D_W = 18 + 2*DW;
    localparam int            E_W = 26 + 3*DW;
    localparam int            M_W = 15 + 2*DW;
    localparam int            W_W = 14 + 2*DW;

    logic             clk = 1'b0;
    logic             rst;
    logic             F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc;
    logic [DW-1:0]    f_predPC;
    logic [D_W-1:0]   d_in;
    logic [E_W-1:0]   e_in;
    logic [M_W-1:0]   m_in;
    logic [W_W-1:0]   w_in;
    logic [2:0]       e_cc;
    logic [DW-1:0]    F_predPC;
    logic [D_W-1:0]   D_out;
    logic [E_W-1:0]   E_out;
    logic [M_W-1:0]   M_out;
    logic [W_W-1:0]   W_out;
    logic [2:0]       cc;
    logic             ctrl_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;

    pipeline_regs #(.DW(DW), .RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble), .E_bubble(E_bubble),
        .M_bubble(M_bubble), .W_stall(W_stall), .set_cc(set_cc),
        .f_predPC(f_predPC), .d_in(d_in), .e_in(e_in), .m_in(m_in), .w_in(w_in), .e_cc(e_cc),
        .F_predPC(F_predPC), .D_out(D_out), .E_out(E_out), .M_out(M_out), .W_out(W_out),
        .cc(cc), .ctrl_err(ctrl_err), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
    task automatic drive_ctrl(input logic [6:0] ctrl);
        {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc} = ctrl;
    endtask

    function automatic logic [D_W-1:0] mk_d(input logic [1:0] stat, input logic [3:0] icode,
        input logic [3:0] ifun, input logic [3:0] ra, input logic [3:0] rb,
        input logic [DW-1:0] valc, input logic [DW-1:0] valp);
        return {stat, icode, ifun, ra, rb, valc, valp};
    endfunction

    function automatic logic [E_W-1:0] mk_e(input logic [1:0] stat, input logic [3:0] icode,
        input logic [3:0] ifun, input logic [DW-1:0] valc, input logic [DW-1:0] vala,
        input logic [DW-1:0] valb, input logic [3:0] dste, input logic [3:0] dstm,
        input logic [3:0] srca, input logic [3:0] srcb);
        return {stat, icode, ifun, valc, vala, valb, dste, dstm, srca, srcb};
    endfunction

    function automatic logic [M_W-1:0] mk_m(input logic [1:0] stat, input logic [3:0] icode,
        input logic cnd, input logic [DW-1:0] vale, input logic [DW-1:0] vala,
        input logic [3:0] dste, input logic [3:0] dstm);
        return {stat, icode, cnd, vale, vala, dste, dstm};
    endfunction

    function automatic logic [W_W-1:0] mk_w(input logic [1:0] stat, input logic [3:0] icode,
        input logic [DW-1:0] vale, input logic [DW-1:0] valm,
        input logic [3:0] dste, input logic [3:0] dstm);
        return {stat, icode, vale, valm, dste, dstm};
    endfunction

    typedef struct {
        logic [6:0]       ctrl;
        logic [DW-1:0]    pc;
        logic [D_W-1:0]   d;
        logic [E_W-1:0]   e;
        logic [M_W-1:0]   m;
        logic [W_W-1:0]   w;
        logic [2:0]       ecc;
        logic [DW-1:0]    exp_f;
        logic [D_W-1:0]   exp_d;
        logic [E_W-1:0]   exp_e;
        logic [M_W-1:0]   exp_m;
        logic [W_W-1:0]   exp_w;
        logic [2:0]       exp_cc;
        logic [CNT_W-1:0] exp_scnt;
        logic [CNT_W-1:0] exp_bcnt;
    } vec_t;

    vec_t vecs[9];

    logic [DW-1:0]  p1, p2, p3;
    logic [D_W-1:0] d1, d2, d3, d7, dx, d_nop;
    logic [E_W-1:0] e1, e2, e3, e_nop;
    logic [M_W-1:0] m1, m2, m3, m_nop;
    logic [W_W-1:0] w1, w2, w3, w_nop;

    initial begin
        p1 = 64'h40;
        p2 = 64'h49;
        p3 = 64'h52;
        d1 = mk_d(2'd0, 4'h3, 4'h0, 4'hF, 4'h2, 64'h0123_4567_89AB_CDEF, 64'h4A);
        d2 = mk_d(2'd0, 4'h5, 4'h0, 4'h1, 4'h6, 64'h10, 64'h53);
        d3 = mk_d(2'd0, 4'h6, 4'h1, 4'h2, 4'h3, 64'h0, 64'h55);
        d7 = mk_d(2'd0, 4'h7, 4'h3, 4'hF, 4'hF, 64'h200, 64'h5E);
        dx = mk_d(2'd3, 4'hE, 4'hC, 4'h9, 4'hA, 64'hDEAD, 64'hBEEF);
        e1 = mk_e(2'd0, 4'h6, 4'h0, 64'h0, 64'h5, 64'h7, 4'h3, 4'hF, 4'h2, 4'h3);
        e2 = mk_e(2'd0, 4'h5, 4'h0, 64'h18, 64'h0, 64'h100, 4'hF, 4'h0, 4'hF, 4'h4);
        e3 = mk_e(2'd0, 4'h3, 4'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'h0, 4'h2, 4'hF, 4'hF, 4'hF);
        m1 = mk_m(2'd0, 4'h6, 1'b1, 64'h99, 64'h11, 4'h1, 4'hF);
        m2 = mk_m(2'd0, 4'h4, 1'b0, 64'h208, 64'h33, 4'hF, 4'hF);
        m3 = mk_m(2'd2, 4'h5, 1'b0, 64'h300, 64'h0, 4'hF, 4'h7);
        w1 = mk_w(2'd0, 4'h6, 64'hAA, 64'h0, 4'h0, 4'hF);
        w2 = mk_w(2'd0, 4'h5, 64'h0, 64'h77, 4'hF, 4'h3);
        w3 = mk_w(2'd1, 4'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        d_nop = mk_d(2'd0, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
        e_nop = mk_e(2'd0, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF, 4'hF, 4'hF);
        m_nop = mk_m(2'd0, 4'h1, 1'b0, 64'h0, 64'h0, 4'hF, 4'hF);
        w_nop = mk_w(2'd0, 4'h1, 64'h0, 64'h0, 4'hF, 4'hF);

        // {ctrl, pc, d, e, m, w, e_cc, exp F, D, E, M, W, cc, stall_cnt, bubble_cnt}
        vecs[0] = '{7'b0000001, p1, d1, e1, m1, w1, 3'b010, p1, d1, e1, m1, w1, 3'b010, 4'd0, 4'd0};
        vecs[1] = '{7'b1101000, p2, d2, e2, m2, w2, 3'b001, p1, d1, e_nop, m2, w2, 3'b010, 4'd1, 4'd1};
        vecs[2] = '{7'b0000001, p3, d3, e3, m3, w3, 3'b111, p3, d3, e3, m3, w3, 3'b111, 4'd1, 4'd1};
        vecs[3] = '{7'b0011000, p1, d7, e1, m1, w1, 3'b000, p1, d_nop, e_nop, m1, w1, 3'b111, 4'd1, 4'd2};
        vecs[4] = '{7'b0000110, p2, d2, e2, m2, w2, 3'b000, p2, d2, e2, m_nop, w1, 3'b111, 4'd1, 4'd3};
        vecs[5] = '{7'b0000110, p3, dx, e3, m3, w3, 3'b010, p3, dx, e3, m_nop, w1, 3'b111, 4'd1, 4'd4};
        vecs[6] = '{7'b0000110, p1, d1, e1, m1, w2, 3'b001, p1, d1, e1, m_nop, w1, 3'b111, 4'd1, 4'd5};
        vecs[7] = '{7'b0000001, p2, d2, e2, m3, w3, 3'b000, p2, d2, e2, m3, w3, 3'b000, 4'd1, 4'd5};
        vecs[8] = '{7'b1000011, p3, d3, e3, m1, w1, 3'b101, p2, d3, e3, m1, w3, 3'b101, 4'd2, 4'd5};

        // Reset with every control asserted: reset must win.
        rst = 1'b1;
        drive_ctrl(7'b1111111);
        f_predPC = p1; d_in = d1; e_in = e1; m_in = m1; w_in = w1; e_cc = 3'b011;
        tick();
        check("reset F_predPC", F_predPC, RESET_PC);
        check("reset D_out", D_out, d_nop);
        check("reset E_out", E_out, e_nop);
        check("reset M_out", M_out, m_nop);
        check("reset W_out", W_out, w_nop);
        check("reset cc", cc, 3'b100);
        check("reset ctrl_err", ctrl_err, 1'b0);
        check("reset stall_cnt", stall_cnt, 4'd0);
        check("reset bubble_cnt", bubble_cnt, 4'd0);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            drive_ctrl(vecs[i].ctrl);
            f_predPC = vecs[i].pc;
            d_in = vecs[i].d; e_in = vecs[i].e; m_in = vecs[i].m; w_in = vecs[i].w;
            e_cc = vecs[i].ecc;
            tick();
            check($sformatf("vec%0d F_predPC", i), F_predPC, vecs[i].exp_f);
            check($sformatf("vec%0d D_out", i), D_out, vecs[i].exp_d);
            check($sformatf("vec%0d E_out", i), E_out, vecs[i].exp_e);
            check($sformatf("vec%0d M_out", i), M_out, vecs[i].exp_m);
            check($sformatf("vec%0d W_out", i), W_out, vecs[i].exp_w);
            check($sformatf("vec%0d cc", i), cc, vecs[i].exp_cc);
            check($sformatf("vec%0d ctrl_err", i), ctrl_err, 1'b0);
            check($sformatf("vec%0d stall_cnt", i), stall_cnt, vecs[i].exp_scnt);
            check($sformatf("vec%0d bubble_cnt", i), bubble_cnt, vecs[i].exp_bcnt);
        end

        // Outputs are registered: new inputs must not show before an edge.
        drive_ctrl(7'b0000001);
        f_predPC = p1; d_in = d1; e_cc = 3'b010;
        #2;
        check("no comb path F", F_predPC, p2);
        check("no comb path D", D_out, d3);
        check("no comb path cc", cc, 3'b101);

        // Stall/bubble conflict on D: D holds, ctrl_err sets and sticks.
        drive_ctrl(7'b0110000);
        d_in = d1;
        tick();
        check("conflict D holds", D_out, d3);
        check("conflict ctrl_err", ctrl_err, 1'b1);
        check("conflict bubble_cnt", bubble_cnt, 4'd6);
        drive_ctrl(7'b0000000);
        d_in = d2;
        tick();
        tick();
        check("after conflict D loads", D_out, d2);
        check("ctrl_err sticky", ctrl_err, 1'b1);

        rst = 1'b1;
        drive_ctrl(7'b1111111);
        tick();
        check("ctrl_err cleared by reset", ctrl_err, 1'b0);
        check("reset2 stall_cnt", stall_cnt, 4'd0);
        check("reset2 bubble_cnt", bubble_cnt, 4'd0);
        check("reset2 F_predPC", F_predPC, RESET_PC);
        rst = 1'b0;

        // Saturation: 20 cycles of F_stall and E_bubble on a 4-bit counter.
        drive_ctrl(7'b1001000);
        f_predPC = p3;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 13) begin
                check("stall_cnt at 14", stall_cnt, 4'd14);
                check("bubble_cnt at 14", bubble_cnt, 4'd14);
            end
            if (i == 14) check("stall_cnt reaches max", stall_cnt, 4'hF);
        end
        check("stall_cnt saturated", stall_cnt, 4'hF);
        check("bubble_cnt saturated", bubble_cnt, 4'hF);
        check("F held during stall", F_predPC, RESET_PC);
        check("E nop during bubble", E_out, e_nop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
